// File: rtl/ro_result_drain.sv
// ro_result_drain
// Reader end of the ring-oscillator result FIFO. Pops power samples and packs
// them into OUT_WIDTH host words, one sample per SLOT_WIDTH slot (slot k at
// bits [k*SLOT_WIDTH +: SLOT_WIDTH], zero-extended, unused slots zero). Words
// leave on a valid/ready stream. A run drains a programmed number of samples,
// flushes any partial final word and then reports done.
//
// Ports:
//   clk, afu_rst      clock, synchronous active-high reset
//   start             single-cycle pulse, latches num_samples and starts a run
//   num_samples       samples to drain this run (0 = none, go straight to done)
//   fifo_empty        result FIFO empty flag
//   fifo_rd_en        FIFO pop request (data returns the following cycle)
//   fifo_rd_data      FIFO read data
//   out_valid/ready   packed-word stream handshake
//   out_data          packed samples
//   out_count         number of occupied slots in out_data
//   out_last          final word of the run
//   busy              run in progress (FILL or SEND)
//   done              run complete, held until the next start
//   overflow_seen     sticky: a popped sample carried the almost-full marker
module ro_result_drain #(
    parameter int FIFO_WIDTH       = 20,
    parameter int ADD_WIDTH        = 19,
    parameter int SLOT_WIDTH       = 32,
    parameter int OUT_WIDTH        = 512,
    parameter int NUM_SAMPLE_WIDTH = 10,
    localparam int SPW = OUT_WIDTH / SLOT_WIDTH,
    localparam int CW  = $clog2(SPW) + 1
) (
    input  logic                        clk,
    input  logic                        afu_rst,
    input  logic                        start,
    input  logic [NUM_SAMPLE_WIDTH-1:0] num_samples,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0]       fifo_rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic [CW-1:0]               out_count,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow_seen
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int NW = NUM_SAMPLE_WIDTH;
    localparam logic [CW-1:0] SPW_C = CW'(SPW);

    state_t                 state_q, state_d;
    logic [NW-1:0]          target_q, target_d;
    logic [CW-1:0]          issued_in_word_q, issued_in_word_d;
    logic [NW-1:0]          issued_total_q, issued_total_d;
    logic [CW-1:0]          captured_in_word_q, captured_in_word_d;
    logic [NW-1:0]          captured_total_q, captured_total_d;
    logic                   rd_pend_q, rd_pend_d;
    logic [OUT_WIDTH-1:0]   word_q, word_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   rd_en;
    logic [SLOT_WIDTH-1:0]  sample;

    always_comb begin
        state_d            = state_q;
        target_d           = target_q;
        issued_in_word_d   = issued_in_word_q;
        issued_total_d     = issued_total_q;
        captured_in_word_d = captured_in_word_q;
        captured_total_d   = captured_total_q;
        word_d             = word_q;
        overflow_d         = overflow_q;
        rd_en              = 1'b0;
        sample             = SLOT_WIDTH'(fifo_rd_data);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (num_samples == '0) begin
                        state_d = S_DONE;
                    end else begin
                        target_d           = num_samples;
                        overflow_d         = 1'b0;
                        issued_in_word_d   = '0;
                        issued_total_d     = '0;
                        captured_in_word_d = '0;
                        captured_total_d   = '0;
                        word_d             = '0;
                        state_d            = S_FILL;
                    end
                end
            end

            S_FILL: begin
                rd_en = !fifo_empty && (issued_in_word_q < SPW_C) &&
                        (issued_total_q < target_q);
                if (rd_en) begin
                    issued_in_word_d = issued_in_word_q + 1'b1;
                    issued_total_d   = issued_total_q + 1'b1;
                end
                // Data for the pop issued last cycle lands now.
                if (rd_pend_q) begin
                    for (int k = 0; k < SPW; k++) begin
                        if (captured_in_word_q == CW'(k)) begin
                            word_d[k*SLOT_WIDTH +: SLOT_WIDTH] = sample;
                        end
                    end
                    captured_in_word_d = captured_in_word_q + 1'b1;
                    captured_total_d   = captured_total_q + 1'b1;
                    if (&fifo_rd_data[ADD_WIDTH-1:0]) begin
                        overflow_d = 1'b1;
                    end
                end
                // Captured counts only reach a limit once every issued read
                // for that limit has landed, so nothing is left in flight.
                if ((captured_in_word_d == SPW_C) ||
                    (captured_total_d == target_q)) begin
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                if (out_ready) begin
                    if (captured_total_q == target_q) begin
                        state_d = S_DONE;
                    end else begin
                        word_d             = '0;
                        issued_in_word_d   = '0;
                        captured_in_word_d = '0;
                        state_d            = S_FILL;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        rd_pend_d = rd_en;
        valid_d   = (state_d == S_SEND);
        busy_d    = (state_d == S_FILL) || (state_d == S_SEND);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (afu_rst) begin
            state_q            <= S_IDLE;
            target_q           <= '0;
            issued_in_word_q   <= '0;
            issued_total_q     <= '0;
            captured_in_word_q <= '0;
            captured_total_q   <= '0;
            rd_pend_q          <= 1'b0;
            word_q             <= '0;
            overflow_q         <= 1'b0;
            valid_q            <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            target_q           <= target_d;
            issued_in_word_q   <= issued_in_word_d;
            issued_total_q     <= issued_total_d;
            captured_in_word_q <= captured_in_word_d;
            captured_total_q   <= captured_total_d;
            rd_pend_q          <= rd_pend_d;
            word_q             <= word_d;
            overflow_q         <= overflow_d;
            valid_q            <= valid_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
        end
    end

    // Pop request must follow fifo_empty in the same cycle, so it is decoded
    // from state rather than registered.
    assign fifo_rd_en    = rd_en;
    assign out_valid     = valid_q;
    assign out_data      = word_q;
    assign out_count     = valid_q ? captured_in_word_q : '0;
    assign out_last      = valid_q && (captured_total_q == target_q);
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow_seen = overflow_q;

endmodule

// File: tb/tb_ro_result_drain.sv
// Testbench for ro_result_drain: behavioural FIFO, randomized stimulus, a
// reference model that packs expected words into a scoreboard queue, and a
// monitor that pops and compares every accepted word.
module tb_ro_result_drain;

    localparam int FW  = 20;
    localparam int SW  = 32;
    localparam int OW  = 512;
    localparam int NW  = 10;
    localparam int SPW = 16;
    localparam int CW  = 5;

    logic          clk = 1'b0;
    logic          afu_rst;
    logic          start;
    logic [NW-1:0] num_samples;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [FW-1:0] fifo_rd_data = '0;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          overflow_seen;

    always #5 clk = ~clk;

    ro_result_drain dut (
        .clk          (clk),
        .afu_rst      (afu_rst),
        .start        (start),
        .num_samples  (num_samples),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .overflow_seen(overflow_seen)
    );

    int n_checks = 0;
    int n_fails  = 0;

    function automatic void chk(string name, logic [OW-1:0] got, logic [OW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Behavioural FIFO: one-cycle read latency, flushed by afu_rst.
    logic [FW-1:0] mem [0:4095];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    int  pops   = 0;
    bit  gate   = 1'b0;
    int  ready_mode = 0;
    int  empty_mode = 0;

    assign fifo_empty = (rd_ptr == wr_ptr) || gate;

    always @(posedge clk) begin
        if (afu_rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
            pops         <= pops + 1;
        end
    end

    // Scoreboard of expected words.
    typedef struct {
        logic [OW-1:0] data;
        logic [CW-1:0] cnt;
        logic          last;
    } word_t;
    word_t sb[$];

    // Reference model: chop the n samples starting at base into SPW groups.
    task automatic build_expect(input int base, input int n, output bit ovf);
        int nwords;
        word_t e;
        logic [FW-1:0] s;
        ovf    = 1'b0;
        nwords = (n + SPW - 1) / SPW;
        for (int w = 0; w < nwords; w++) begin
            e.data = '0;
            e.cnt  = '0;
            for (int k = 0; k < SPW; k++) begin
                if (w * SPW + k < n) begin
                    s = mem[base + w * SPW + k];
                    e.data[k*SW +: SW] = {12'b0, s};
                    e.cnt = e.cnt + 1'b1;
                    if (s[18:0] == 19'h7FFFF) ovf = 1'b1;
                end
            end
            e.last = (w == nwords - 1);
            sb.push_back(e);
        end
    endtask

    // Monitor.
    int viol_empty   = 0;
    int viol_send_rd = 0;
    int stall_cnt    = 0;

    initial begin
        logic [OW-1:0] s_data;
        logic [CW-1:0] s_cnt;
        logic          s_last;
        bit            stall, hs_prev, done_next;
        word_t         e;
        stall = 0; hs_prev = 0; done_next = 0;
        s_data = '0; s_cnt = '0; s_last = 1'b0;
        forever begin
            @(negedge clk);
            if (afu_rst) begin
                stall = 0; hs_prev = 0; done_next = 0;
            end else begin
                if (fifo_rd_en && fifo_empty) viol_empty++;
                if (out_valid && fifo_rd_en) viol_send_rd++;
                if (hs_prev) chk("valid_drop", out_valid, 0);
                if (done_next) chk("done_after_last", done, 1);
                if (stall && out_valid) begin
                    stall_cnt++;
                    chk("stall_data", out_data, s_data);
                    chk("stall_count", out_count, s_cnt);
                    chk("stall_last", out_last, s_last);
                end
                hs_prev = 0; done_next = 0; stall = 0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_word", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("word_data", out_data, e.data);
                        chk("word_count", out_count, e.cnt);
                        chk("word_last", out_last, e.last);
                        done_next = e.last;
                    end
                    hs_prev = 1;
                end else if (out_valid) begin
                    stall  = 1;
                    s_data = out_data;
                    s_cnt  = out_count;
                    s_last = out_last;
                end
            end
        end
    end

    // out_ready driver: 0 always ready, 1 random, 2 hold low 10 cycles per word.
    initial begin
        int vc;
        vc = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (out_valid) begin
                        out_ready = (vc >= 10);
                        vc++;
                    end else begin
                        vc = 0;
                        out_ready = 1'b0;
                    end
                end
            endcase
        end
    end

    // fifo_empty gating driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            gate = (empty_mode != 0) && ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start       = 1'b1;
        num_samples = NW'(n);
        tick();
        start = 1'b0;
    endtask

    // mode 0: values 1..n, mode 1: random without marker; ovf_at plants 0x7FFFF.
    task automatic preload(input int n, input int mode, input int ovf_at);
        logic [FW-1:0] v;
        for (int i = 0; i < n; i++) begin
            if (mode == 0) begin
                v = FW'(i + 1);
            end else begin
                v = FW'($urandom);
                if (v[18:0] == 19'h7FFFF) v[0] = 1'b0;
            end
            if (i == ovf_at) v = 20'h7FFFF;
            mem[wr_ptr] = v;
            wr_ptr++;
        end
    endtask

    task automatic run(input string tag, input int n, input int mode, input int ovf_at);
        int base, p0, ve0, vs0, st0;
        bit exp_ovf, got_done;
        base = wr_ptr;
        preload(n, mode, ovf_at);
        build_expect(base, n, exp_ovf);
        p0 = pops; ve0 = viol_empty; vs0 = viol_send_rd; st0 = stall_cnt;
        do_start(n);
        @(negedge clk);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_ovf_cleared"}, overflow_seen, 0);
        got_done = 0;
        for (int c = 0; c < 30 * n + 200; c++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                break;
            end
        end
        chk({tag, "_done"}, got_done, 1);
        chk({tag, "_pops"}, pops - p0, n);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_overflow"}, overflow_seen, exp_ovf);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_rd_while_empty"}, viol_empty - ve0, 0);
        chk({tag, "_rd_in_send"}, viol_send_rd - vs0, 0);
        if (ready_mode == 2) chk({tag, "_stalled"}, (stall_cnt - st0) >= 10, 1);
        sb.delete();
        tick();
    endtask

    initial begin
        int seen, n;
        afu_rst = 1'b1; start = 1'b0; num_samples = '0;
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_count", out_count, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow_seen, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        afu_rst = 1'b0;
        tick();

        run("t1_one_word", 16, 0, -1);
        run("t2_two_words", 20, 0, -1);
        ready_mode = 2;
        run("t3_backpressure", 20, 1, -1);
        ready_mode = 1; empty_mode = 1;
        run("t4_empty_toggle", 40, 1, -1);
        ready_mode = 0; empty_mode = 0;
        run("t5_overflow", 24, 1, 9);
        run("t5_ovf_clear", 5, 1, -1);

        // Zero-sample run from IDLE.
        afu_rst = 1'b1;
        tick();
        afu_rst = 1'b0;
        chk("t6_done_idle", done, 0);
        do_start(0);
        @(negedge clk);
        chk("t6_zero_done", done, 1);
        chk("t6_zero_busy", busy, 0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("t6_zero_no_word", seen, 0);
        tick();

        // Reset in the middle of FILL.
        preload(40, 1, -1);
        do_start(40);
        repeat (6) tick();
        chk("t6_mid_fill_busy", busy, 1);
        afu_rst = 1'b1;
        tick();
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_count", out_count, 0);
        chk("t6_rst_last", out_last, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_ovf", overflow_seen, 0);
        chk("t6_rst_rd_en", fifo_rd_en, 0);
        afu_rst = 1'b0;
        sb.delete();
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("t6_rst_no_word", seen, 0);
        tick();

        // Randomized runs, including single-sample and full-range targets.
        run("t7_single", 1, 1, -1);
        for (int r = 0; r < 5; r++) begin
            ready_mode = int'($urandom_range(0, 1));
            empty_mode = int'($urandom_range(0, 1));
            n = int'($urandom_range(1, 70));
            run("t7_rand", n, 1, (r == 2) ? n / 2 : -1);
        end
        ready_mode = 1; empty_mode = 1;
        run("t7_32", 32, 1, -1);
        ready_mode = 0; empty_mode = 0;
        run("t8_max", 1023, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ro_result_drain.md
Name: ro_result_drain

Overview:
- Reader end of the ring-oscillator result FIFO. Pops power samples from the FIFO with its read handshake and packs them into wide host words, one sample per fixed slot.
- Presents the packed words on a valid/ready stream toward the host DMA/CSR write path.
- Stops after a programmed number of samples, zero-pads and flushes any partial final word, then reports done.

Parameters:
FIFO_WIDTH, 20, width of fifo_rd_data
ADD_WIDTH, 19, width of the sample payload inside a FIFO word; all-ones payload is the FIFO almost-full marker
SLOT_WIDTH, 32, bits reserved per sample in an output word (must be >= FIFO_WIDTH)
OUT_WIDTH, 512, output word width; SPW = OUT_WIDTH/SLOT_WIDTH samples per word (16 by default)
NUM_SAMPLE_WIDTH, 10, width of num_samples

Ports:
clk  in  1  clock
afu_rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse; latches num_samples and begins a drain run
num_samples  in  NUM_SAMPLE_WIDTH  total samples to drain this run; 0 means none
fifo_empty  in  1  result FIFO empty flag
fifo_rd_en  out  1  FIFO pop request
fifo_rd_data  in  FIFO_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
out_valid  out  1  packed word available
out_ready  in  1  downstream accepts word when out_valid && out_ready
out_data  out  OUT_WIDTH  packed samples
out_count  out  $clog2(SPW)+1  number of valid slots in out_data
out_last  out  1  word is the final word of the run
busy  out  1  run in progress
done  out  1  run complete; held until next start
overflow_seen  out  1  sticky: a popped sample had an all-ones payload

Behaviour:
- Reset is synchronous, clk only. All outputs are 0 the cycle after afu_rst is seen high, including out_data. Internal counters and the state go to IDLE. Any in-flight FIFO read data is discarded.
- States: IDLE, FILL, SEND, DONE.
- IDLE:
  - start with num_samples=0 goes to DONE.
  - start with num_samples>0 latches target=num_samples, clears overflow_seen and the slot counters, and goes to FILL.
- FILL:
  - fifo_rd_en = !fifo_empty && issued_in_word < SPW && issued_total < target. Back-to-back pops are allowed. fifo_rd_en is never high while fifo_empty=1.
  - The read issued at cycle t is captured at t+1 into slot captured_in_word.
  - Slot k occupies bits [k*SLOT_WIDTH +: SLOT_WIDTH]. The sample is zero-extended; unused slots are 0.
  - Leave for SEND when captured_in_word==SPW, or when captured_total==target, after the last outstanding read has landed.
- SEND:
  - out_valid=1. out_count = captured_in_word. out_last = (captured_total==target).
  - fifo_rd_en=0 throughout SEND.
  - out_data, out_count and out_last are stable while out_valid && !out_ready.
  - On handshake: if out_last, go to DONE; otherwise clear the word and the per-word counters and go to FILL.
  - out_valid drops the cycle after the handshake. At most one word per 2 cycles.
- DONE: done=1, busy=0. start re-arms exactly as from IDLE, and done drops the next cycle.
- busy=1 in FILL and SEND. start is ignored while busy.
- Overflow: any captured sample whose low ADD_WIDTH bits are all ones sets overflow_seen. The sample is still packed unchanged.
- Counters are wide enough for target = 2^NUM_SAMPLE_WIDTH-1 and never wrap within a run.
- Reset mid-run returns the block to IDLE with no word emitted. The FIFO shares afu_rst.

Test Plan:
1. Preload FIFO with 1..16; start, num_samples=16, out_ready=1 -> one word, slot k = k+1, out_count=16, out_last=1; done=1 the cycle after the handshake.
2. num_samples=20, FIFO holds 1..20 -> word 1 has slots 1..16, out_last=0. Word 2 has slots 0-3 = 17..20 and slots 4-15 = 0, out_count=4, out_last=1.
3. Backpressure: hold out_ready=0 for 10 cycles in SEND -> out_data, out_count and out_last are unchanged and fifo_rd_en=0 throughout. Accept on cycle 11 -> FILL resumes.
4. fifo_empty toggled pseudo-randomly over 40 samples -> fifo_rd_en is never high while empty, samples appear in FIFO order, and exactly 40 pops occur.
5. One sample = 0x7FFFF among normal values -> overflow_seen=1, 0x7FFFF present in its slot. The next start clears overflow_seen.
6. num_samples=0 -> done=1 one cycle after start, no out_valid. Separately, assert afu_rst mid-FILL -> all outputs 0 next cycle and no word is emitted.
